apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_if.sv | 43 ++++
 rtl/apb_req_arbiter.sv | 128 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - request/response and APB5 bus bundle for apb_req_arbiter
interface apb_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_write;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [5:0]              req_prot;

    logic [1:0]              resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_prot,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_prot,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin arbiter driving an APB5 requester port
module apb_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                pclk,
    input  logic                preset_n,
    apb_req_arbiter_if.master   bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  owner;

    logic                  grant;
    logic                  can_accept;
    logic [1:0]            ready;
    logic                  accept;

    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [2:0]            win_prot;
    logic                  win_write;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [2:0]            pprot_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [1:0]            resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req_valid[1];
        end
    end

    assign can_accept = (state == ST_IDLE) || ((state == ST_ACCESS) && bus.pready);
    assign ready      = can_accept ? (bus.req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
    assign accept     = |ready;

    assign win_addr  = grant ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : bus.req_addr[0 +: ADDR_WIDTH];
    assign win_wdata = grant ? bus.req_wdata[DATA_WIDTH +: DATA_WIDTH] : bus.req_wdata[0 +: DATA_WIDTH];
    assign win_prot  = grant ? bus.req_prot[5:3] : bus.req_prot[2:0];
    assign win_write = grant ? bus.req_write[1]  : bus.req_write[0];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 2'b00;
            if (state == ST_ACCESS && bus.pready) begin
                resp_valid_q <= owner ? 2'b10 : 2'b01;
                resp_err_q   <= bus.pslverr;
                resp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            end

            // A new command can be taken from IDLE or straight out of a completing ACCESS.
            if (accept) begin
                state      <= ST_SETUP;
                last_grant <= grant;
                owner      <= grant;
                paddr_q    <= win_addr;
                pprot_q    <= win_prot;
                pwrite_q   <= win_write;
                pwdata_q   <= win_wdata;
                pstrb_q    <= win_write ? {STRB_W{1'b1}} : '0;
                psel_q     <= 1'b1;
                penable_q  <= 1'b0;
            end else begin
                case (state)
                    ST_SETUP: begin
                        state     <= ST_ACCESS;
                        penable_q <= 1'b1;
                    end
                    ST_ACCESS: begin
                        if (bus.pready) begin
                            state     <= ST_IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            paddr_q   <= '0;
                            pwdata_q  <= '0;
                            pstrb_q   <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.paddr      = paddr_q;
    assign bus.pprot      = pprot_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;
    logic pclk;
    logic preset_n;
    int   compared;
    int   mismatched;

    apb_req_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_req_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        preset_n   = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_prot  = '0;
        bus.pready    = 1'b1;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;

        #3;
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pstrb", bus.pstrb, 4'h0);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        tick();
        tick();
        preset_n = 1'b1;
        tick();

        // single write from requester 0
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr[31:0]  = 32'h84;
        bus.req_wdata[31:0] = 32'h12345678;
        bus.req_prot[2:0]   = 3'b010;
        #1;
        chk("w_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("w_setup_psel", bus.psel, 1'b1);
        chk("w_setup_pen", bus.penable, 1'b0);
        chk("w_paddr", bus.paddr, 32'h84);
        chk("w_pwdata", bus.pwdata, 32'h12345678);
        chk("w_pstrb", bus.pstrb, 4'hF);
        chk("w_pprot", bus.pprot, 3'b010);
        chk("w_pwrite", bus.pwrite, 1'b1);
        tick();
        chk("w_access_pen", bus.penable, 1'b1);
        chk("w_access_psel", bus.psel, 1'b1);
        tick();
        chk("w_resp_valid", bus.resp_valid, 2'b01);
        chk("w_resp_err", bus.resp_err, 1'b0);
        chk("w_resp_rdata", bus.resp_rdata, 32'h0);
        chk("w_idle_psel", bus.psel, 1'b0);
        chk("w_idle_paddr", bus.paddr, 32'h0);
        chk("w_idle_pstrb", bus.pstrb, 4'h0);
        chk("w_idle_pwrite_hold", bus.pwrite, 1'b1);
        chk("w_idle_pprot_hold", bus.pprot, 3'b010);
        tick();
        chk("w_resp_pulse_end", bus.resp_valid, 2'b00);

        // read from requester 1 with three wait states
        bus.pready = 1'b0;
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr[63:32] = 32'h84;
        bus.req_prot[5:3]   = 3'b101;
        tick();
        bus.req_valid = 2'b00;
        chk("r_setup_psel", bus.psel, 1'b1);
        chk("r_pstrb", bus.pstrb, 4'h0);
        chk("r_pwrite", bus.pwrite, 1'b0);
        chk("r_pprot", bus.pprot, 3'b101);
        tick();
        chk("r_access_pen", bus.penable, 1'b1);
        bus.req_valid = 2'b01;
        #1;
        chk("r_no_accept_wait", bus.req_ready, 2'b00);
        bus.req_valid = 2'b00;
        tick();
        chk("r_wait1_pen", bus.penable, 1'b1);
        chk("r_wait1_paddr", bus.paddr, 32'h84);
        chk("r_wait1_resp", bus.resp_valid, 2'b00);
        tick();
        chk("r_wait2_psel", bus.psel, 1'b1);
        chk("r_wait2_resp", bus.resp_valid, 2'b00);
        tick();
        chk("r_wait3_pen", bus.penable, 1'b1);
        chk("r_wait3_paddr", bus.paddr, 32'h84);
        bus.pready = 1'b1;
        bus.prdata = 32'h12345678;
        tick();
        chk("r_resp_valid", bus.resp_valid, 2'b10);
        chk("r_resp_rdata", bus.resp_rdata, 32'h12345678);
        chk("r_resp_err", bus.resp_err, 1'b0);
        bus.prdata = '0;
        tick();

        // round-robin from reset with both requesters valid
        preset_n = 1'b0;
        tick();
        preset_n = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b11;
        bus.req_addr  = {32'h200, 32'h100};
        #1;
        chk("rr_first_ready", bus.req_ready, 2'b01);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d_psel", k), bus.psel, 1'b1);
            chk($sformatf("rr%0d_pen", k), bus.penable, 1'b0);
            chk($sformatf("rr%0d_paddr", k), bus.paddr, (k % 2 == 0) ? 32'h100 : 32'h200);
            if (k > 0)
                chk($sformatf("rr%0d_prev_resp", k), bus.resp_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 3)
                bus.req_valid = 2'b00;
            tick();
            chk($sformatf("rr%0d_access_psel", k), bus.psel, 1'b1);
            chk($sformatf("rr%0d_access_pen", k), bus.penable, 1'b1);
            chk($sformatf("rr%0d_ready", k), bus.req_ready,
                (k == 3) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01));
        end
        tick();
        chk("rr_last_resp", bus.resp_valid, 2'b10);
        chk("rr_end_psel", bus.psel, 1'b0);

        // error response, then a normal read
        bus.pslverr = 1'b1;
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        chk("err_resp_valid", bus.resp_valid, 2'b01);
        chk("err_resp_err", bus.resp_err, 1'b1);
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hCAFEF00D;
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        chk("after_err_resp_valid", bus.resp_valid, 2'b10);
        chk("after_err_resp_err", bus.resp_err, 1'b0);
        chk("after_err_rdata", bus.resp_rdata, 32'hCAFEF00D);
        tick();

        // reset asserted mid-ACCESS
        bus.pready = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("mr_access_pen", bus.penable, 1'b1);
        #2;
        preset_n = 1'b0;
        #1;
        chk("mr_psel_async", bus.psel, 1'b0);
        chk("mr_pen_async", bus.penable, 1'b0);
        chk("mr_paddr_async", bus.paddr, 32'h0);
        bus.pready = 1'b1;
        tick();
        chk("mr_no_resp", bus.resp_valid, 2'b00);
        preset_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("mr_tie_ready", bus.req_ready, 2'b01);
        tick();
        chk("mr_tie_paddr", bus.paddr, 32'h100);
        chk("mr_tie_resp", bus.resp_valid, 2'b00);
        bus.req_valid = 2'b00;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
